regfile_write_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32×32 MIPS register file. Two producers compete for the single register-file write port: requester 0 is the ALU writeback and requester 1 is the load return. The block grants them round-robin, registers the winning write onto `regWrite`/`writeRegister`/`writeData`, and tracks pending destination registers so decode can stall on read-after-write hazards. It sits between the pipeline back end and the register file.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_write_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 tb/tb_regfile_write_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter and scoreboard.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } grant_t;

  // 'reg' is a keyword, so the destination field is reg_idx.
  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of request, reservation, hazard and register-file write signals around the arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic              req0Valid;
  logic [ADDR_W-1:0] req0Reg;
  logic [DATA_W-1:0] req0Data;
  logic              req0Ready;

  logic              req1Valid;
  logic [ADDR_W-1:0] req1Reg;
  logic [DATA_W-1:0] req1Data;
  logic              req1Ready;

  logic              reserveValid;
  logic [ADDR_W-1:0] reserveReg;
  logic              flush;

  logic [ADDR_W-1:0] register1;
  logic [ADDR_W-1:0] register2;
  logic              hazard1;
  logic              hazard2;

  logic                regWrite;
  logic [ADDR_W-1:0]   writeRegister;
  logic [DATA_W-1:0]   writeData;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output req0Valid, req0Reg, req0Data, req1Valid, req1Reg, req1Data,
           reserveValid, reserveReg, flush, register1, register2,
    input  req0Ready, req1Ready, hazard1, hazard2,
           regWrite, writeRegister, writeData, pending
  );

  modport slave (
    input  req0Valid, req0Reg, req0Data, req1Valid, req1Reg, req1Data,
           reserveValid, reserveReg, flush, register1, register2,
    output req0Ready, req1Ready, hazard1, hazard2,
           regWrite, writeRegister, writeData, pending
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; remembers the last requester that completed a transfer.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clock,
  input  logic resetN,
  input  logic valid0,
  input  logic valid1,
  input  logic xfer,
  output logic grant0,
  output logic grant1
);

  grant_t last_grant;
  grant_t last_grant_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) last_grant <= LAST1;
    else         last_grant <= last_grant_next;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    last_grant_next = last_grant;
    if (xfer && grant0)      last_grant_next = LAST0;
    else if (xfer && grant1) last_grant_next = LAST1;
  end

  always_comb begin
    grant0 = valid0 && (!valid1 || (last_grant == LAST1));
    grant1 = valid1 && (!valid0 || (last_grant == LAST0));
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter with registered write stage and RAW scoreboard for the register file.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                    clock,
  input  logic                    resetN,
  regfile_write_arbiter_if.slave  bus
);

  logic                grant0;
  logic                grant1;
  logic                transfer;
  wr_req_t             winner;

  logic                reg_write_q;
  logic [ADDR_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]   write_data_q;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_next;

  rr_arbiter2 u_arb (
    .clock  (clock),
    .resetN (resetN),
    .valid0 (bus.req0Valid),
    .valid1 (bus.req1Valid),
    .xfer   (transfer),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign bus.req0Ready = grant0;
  assign bus.req1Ready = grant1;
  assign transfer      = (bus.req0Valid && grant0) || (bus.req1Valid && grant1);

  always_comb begin
    winner = '{reg_idx: bus.req1Reg, data: bus.req1Data};
    if (grant0) winner = '{reg_idx: bus.req0Reg, data: bus.req0Data};
  end

  // Register 0 writes are accepted but never strobe the register file.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q <= transfer && (winner.reg_idx != ZERO_REG);
      if (transfer) begin
        write_reg_q  <= winner.reg_idx;
        write_data_q <= winner.data;
      end
    end
  end

  // Order matters: flush, then retire, then reserve, so the newest producer wins.
  always_comb begin
    pending_next = pending_q;
    if (bus.flush) pending_next = '0;
    if (transfer) pending_next[winner.reg_idx] = 1'b0;
    if (bus.reserveValid && (bus.reserveReg != ZERO_REG))
      pending_next[bus.reserveReg] = 1'b1;
    pending_next[ZERO_REG] = 1'b0;
  end

  // NOTE: the scoreboard is a plain flop vector, not a RAM, so it can and does take the async reset.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) pending_q <= '0;
    else         pending_q <= pending_next;
  end

  always_comb begin
    bus.hazard1 = pending_q[bus.register1] ||
                  (reg_write_q && (write_reg_q == bus.register1) && (bus.register1 != ZERO_REG));
    bus.hazard2 = pending_q[bus.register2] ||
                  (reg_write_q && (write_reg_q == bus.register2) && (bus.register2 != ZERO_REG));
  end

  assign bus.regWrite      = reg_write_q;
  assign bus.writeRegister = write_reg_q;
  assign bus.writeData     = write_data_q;
  assign bus.pending       = pending_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, async-reset sequence, random run against a reference model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which requester went last, pending set, and the write sitting in the output stage.
  int          m_last;
  bit          m_pend [NUM_REGS];
  bit          m_ow;
  int          m_oreg;
  logic [31:0] m_odata;
  int          m_grant = -1;

  typedef struct {
    logic v0; logic [4:0] r0; logic [31:0] d0;
    logic v1; logic [4:0] r1; logic [31:0] d1;
    logic rv; logic [4:0] rr; logic fl;
    logic [4:0] s1; logic [4:0] s2;
    logic e_rdy0; logic e_rdy1; logic e_h1; logic e_h2;
    logic e_rw; logic [4:0] e_wreg; logic [31:0] e_wdata; logic [31:0] e_pend;
  } vec_t;

  vec_t vecs [15];
  vec_t none;

  function automatic vec_t mk(int v0, int r0, int d0, int v1, int r1, int d1,
                              int rv, int rr, int fl, int s1, int s2,
                              int rdy0, int rdy1, int h1, int h2,
                              int rw, int wreg, int wdata, int pend);
    vec_t v;
    v.v0 = 1'(v0); v.r0 = 5'(r0); v.d0 = 32'(d0);
    v.v1 = 1'(v1); v.r1 = 5'(r1); v.d1 = 32'(d1);
    v.rv = 1'(rv); v.rr = 5'(rr); v.fl = 1'(fl);
    v.s1 = 5'(s1); v.s2 = 5'(s2);
    v.e_rdy0 = 1'(rdy0); v.e_rdy1 = 1'(rdy1); v.e_h1 = 1'(h1); v.e_h2 = 1'(h2);
    v.e_rw = 1'(rw); v.e_wreg = 5'(wreg); v.e_wdata = 32'(wdata); v.e_pend = 32'(pend);
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_ow    = 1'b0;
    m_oreg  = 0;
    m_odata = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  function automatic int model_grant();
    if (bus.req0Valid && bus.req1Valid) return (m_last == 1) ? 0 : 1;
    if (bus.req0Valid) return 0;
    if (bus.req1Valid) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit model_hazard(int r);
    return m_pend[r] || (m_ow && (m_oreg == r) && (r != 0));
  endfunction

  task automatic model_update();
    int          r;
    logic [31:0] d;
    if (bus.flush) foreach (m_pend[i]) m_pend[i] = 1'b0;
    if (m_grant >= 0) begin
      r = (m_grant == 0) ? int'(bus.req0Reg) : int'(bus.req1Reg);
      d = (m_grant == 0) ? bus.req0Data : bus.req1Data;
      m_pend[r] = 1'b0;
      m_oreg    = r;
      m_odata   = d;
      m_ow      = (r != 0);
      m_last    = m_grant;
    end else begin
      m_ow = 1'b0;
    end
    if (bus.reserveValid && (bus.reserveReg != 5'd0)) m_pend[bus.reserveReg] = 1'b1;
  endtask

  task automatic set_idle();
    bus.req0Valid = 1'b0; bus.req0Reg = '0; bus.req0Data = '0;
    bus.req1Valid = 1'b0; bus.req1Reg = '0; bus.req1Data = '0;
    bus.reserveValid = 1'b0; bus.reserveReg = '0; bus.flush = 1'b0;
    bus.register1 = '0; bus.register2 = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.req0Valid = v.v0; bus.req0Reg = v.r0; bus.req0Data = v.d0;
    bus.req1Valid = v.v1; bus.req1Reg = v.r1; bus.req1Data = v.d1;
    bus.reserveValid = v.rv; bus.reserveReg = v.rr; bus.flush = v.fl;
    bus.register1 = v.s1; bus.register2 = v.s2;
  endtask

  // Inputs are set just after a rising edge; combinational outputs are checked 1ns later,
  // registered outputs 1ns after the next rising edge.
  task automatic run_cycle(input bit use_tab, input vec_t v, input string tag);
    #1;
    m_grant = model_grant();
    check({tag, " req0Ready"}, 64'(bus.req0Ready), 64'(m_grant == 0));
    check({tag, " req1Ready"}, 64'(bus.req1Ready), 64'(m_grant == 1));
    check({tag, " hazard1"},   64'(bus.hazard1),   64'(model_hazard(int'(bus.register1))));
    check({tag, " hazard2"},   64'(bus.hazard2),   64'(model_hazard(int'(bus.register2))));
    if (use_tab) begin
      check({tag, " tab req0Ready"}, 64'(bus.req0Ready), 64'(v.e_rdy0));
      check({tag, " tab req1Ready"}, 64'(bus.req1Ready), 64'(v.e_rdy1));
      check({tag, " tab hazard1"},   64'(bus.hazard1),   64'(v.e_h1));
      check({tag, " tab hazard2"},   64'(bus.hazard2),   64'(v.e_h2));
    end
    @(posedge clock);
    model_update();
    #1;
    check({tag, " regWrite"},      64'(bus.regWrite),      64'(m_ow));
    check({tag, " writeRegister"}, 64'(bus.writeRegister), 64'(m_oreg));
    check({tag, " writeData"},     64'(bus.writeData),     64'(m_odata));
    check({tag, " pending"},       64'(bus.pending),       64'(model_pend_vec()));
    if (use_tab) begin
      check({tag, " tab regWrite"},      64'(bus.regWrite),      64'(v.e_rw));
      check({tag, " tab writeRegister"}, 64'(bus.writeRegister), 64'(v.e_wreg));
      check({tag, " tab writeData"},     64'(bus.writeData),     64'(v.e_wdata));
      check({tag, " tab pending"},       64'(bus.pending),       64'(v.e_pend));
    end
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    none = mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    //             v0 r0 d0       v1 r1 d1       rv rr fl s1 s2  rdy0 rdy1 h1 h2  rw wreg wdata     pend
    vecs[0]  = mk(1, 5, 'hAAAA,  1, 6, 'hBBBB,  0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 5, 'hAAAA, 'h0);
    vecs[1]  = mk(1, 5, 'hAAAA,  1, 6, 'hBBBB,  0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 6, 'hBBBB, 'h0);
    vecs[2]  = mk(1, 5, 'hAAAA,  1, 6, 'hBBBB,  0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 5, 'hAAAA, 'h0);
    vecs[3]  = mk(1, 5, 'hAAAA,  1, 6, 'hBBBB,  0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 6, 'hBBBB, 'h0);
    vecs[4]  = mk(0, 0, 0,       0, 0, 0,       1, 8, 0, 8, 0,  0, 0, 0, 0,  0, 6, 'hBBBB, 'h100);
    vecs[5]  = mk(1, 8, 'h1234,  0, 0, 0,       0, 0, 0, 8, 0,  1, 0, 1, 0,  1, 8, 'h1234, 'h0);
    vecs[6]  = mk(0, 0, 0,       0, 0, 0,       0, 0, 0, 8, 0,  0, 0, 1, 0,  0, 8, 'h1234, 'h0);
    vecs[7]  = mk(0, 0, 0,       0, 0, 0,       0, 0, 0, 8, 0,  0, 0, 0, 0,  0, 8, 'h1234, 'h0);
    vecs[8]  = mk(1, 0, 'hFFFF,  0, 0, 0,       1, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 'hFFFF, 'h0);
    vecs[9]  = mk(0, 0, 0,       1, 9, 'h9999,  1, 9, 0, 0, 9,  0, 1, 0, 0,  1, 9, 'h9999, 'h200);
    vecs[10] = mk(0, 0, 0,       0, 0, 0,       1, 10, 1, 0, 9, 0, 0, 0, 1,  0, 9, 'h9999, 'h400);
    vecs[11] = mk(0, 0, 0,       0, 0, 0,       0, 0, 0, 10, 9, 0, 0, 1, 0,  0, 9, 'h9999, 'h400);
    vecs[12] = mk(1, 3, 'h33,    1, 4, 'h44,    1, 11, 0, 0, 0, 1, 0, 0, 0,  1, 3, 'h33,   'hC00);
    vecs[13] = mk(1, 3, 'h33,    1, 4, 'h44,    0, 0, 1, 0, 0,  0, 1, 0, 0,  1, 4, 'h44,   'h0);
    vecs[14] = mk(0, 0, 0,       0, 0, 0,       0, 0, 0, 4, 0,  0, 0, 1, 0,  0, 4, 'h44,   'h0);

    set_idle();
    resetN = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset regWrite", 64'(bus.regWrite), 64'(0));
    check("reset pending",  64'(bus.pending),  64'(0));
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 15; i++) begin
      apply_vec(vecs[i]);
      run_cycle(1'b1, vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset with a write in the output stage and pending = 0x300.
    set_idle();
    bus.reserveValid = 1'b1; bus.reserveReg = 5'd8;
    run_cycle(1'b0, none, "rst_setup0");
    set_idle();
    bus.req0Valid = 1'b1; bus.req0Reg = 5'd2; bus.req0Data = 32'h22;
    bus.reserveValid = 1'b1; bus.reserveReg = 5'd9;
    run_cycle(1'b0, none, "rst_setup1");
    check("pre-reset regWrite", 64'(bus.regWrite), 64'(1));
    check("pre-reset pending",  64'(bus.pending),  64'(32'h300));
    set_idle();
    bus.register1 = 5'd9;
    bus.register2 = 5'd2;
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    check("async regWrite",      64'(bus.regWrite),      64'(0));
    check("async pending",       64'(bus.pending),       64'(0));
    check("async writeRegister", 64'(bus.writeRegister), 64'(0));
    check("async writeData",     64'(bus.writeData),     64'(0));
    check("async hazard1",       64'(bus.hazard1),       64'(0));
    check("async hazard2",       64'(bus.hazard2),       64'(0));
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
    bus.req0Valid = 1'b1; bus.req0Reg = 5'd5; bus.req0Data = 32'hAAAA;
    bus.req1Valid = 1'b1; bus.req1Reg = 5'd6; bus.req1Data = 32'hBBBB;
    #1;
    check("post-reset grant0", 64'(bus.req0Ready), 64'(1));
    check("post-reset grant1", 64'(bus.req1Ready), 64'(0));
    run_cycle(1'b0, none, "post_rst");

    // Random traffic; a requester left waiting keeps its request unchanged.
    for (int i = 0; i < 400; i++) begin
      if (!(bus.req0Valid && (m_grant != 0))) begin
        bus.req0Valid = ($urandom_range(0, 3) != 0);
        bus.req0Reg   = rnd_reg();
        bus.req0Data  = $urandom();
      end
      if (!(bus.req1Valid && (m_grant != 1))) begin
        bus.req1Valid = ($urandom_range(0, 3) != 0);
        bus.req1Reg   = rnd_reg();
        bus.req1Data  = $urandom();
      end
      bus.reserveValid = 1'($urandom_range(0, 1));
      bus.reserveReg   = rnd_reg();
      bus.flush        = ($urandom_range(0, 15) == 0);
      bus.register1    = rnd_reg();
      bus.register2    = rnd_reg();
      run_cycle(1'b0, none, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
